// File: rtl/viterbi_traceback_if.sv
// Bundle of the traceback block's control, trellis-memory and bit-stream
// signals. The master side is the surrounding decoder / sink; the slave
// side is viterbi_traceback.
interface viterbi_traceback_if #(
  parameter int NUM_ST = 256,
  parameter int ST_W   = 8,
  parameter int CNT_W  = 6
);
  logic                           en_tb;
  logic [NUM_ST-1:0][ST_W-1:0]    i_bck_prv_st;
  logic                           i_td_full;
  logic                           i_td_empty;
  logic                           i_ood;
  logic [CNT_W-1:0]               i_tb_len;
  logic [ST_W-1:0]                i_min_st;
  logic                           i_rdy;
  logic                           o_tb_rd;
  logic                           o_data;
  logic                           o_valid;
  logic                           o_done;
  logic                           o_busy;
  logic                           o_err;

  modport master (
    output en_tb, i_bck_prv_st, i_td_full, i_td_empty, i_ood, i_tb_len,
           i_min_st, i_rdy,
    input  o_tb_rd, o_data, o_valid, o_done, o_busy, o_err
  );

  modport slave (
    input  en_tb, i_bck_prv_st, i_td_full, i_td_empty, i_ood, i_tb_len,
           i_min_st, i_rdy,
    output o_tb_rd, o_data, o_valid, o_done, o_busy, o_err
  );
endinterface

// File: rtl/viterbi_traceback.sv
// Viterbi traceback (K=9, 256 states). Walks predecessor pointers from the
// best-metric state one stage per cycle, buffers the recovered bits
// (produced newest-first) and replays them oldest-first on a valid/ready
// bit stream.
// Optional macro ZERO_TERM_EN: an i_ood-triggered start begins from state 0
// (zero-tail terminated frame) instead of i_min_st.
module viterbi_traceback #(
  parameter int NUM_ST   = 256,
  parameter int ST_W     = 8,
  parameter int TB_DEPTH = 45,
  parameter int CNT_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_traceback_if.slave   tb_if
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACE  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

  state_e               state_r;
  state_e               state_nx_s;
  logic [CNT_W-1:0]     len_r;
  logic [CNT_W-1:0]     step_r;
  logic [CNT_W-1:0]     rd_idx_r;
  logic [ST_W-1:0]      cur_st_r;
  logic [TB_DEPTH-1:0]  buf_r;
  logic                 done_r;
  logic                 err_r;

  logic                 start_s;
  logic [CNT_W-1:0]     start_len_s;
  logic [ST_W-1:0]      start_st_s;
  logic [CNT_W-1:0]     wr_idx_s;
  logic                 last_step_s;
  logic                 last_beat_s;
  logic                 tb_rd_s;
  logic                 valid_s;

  // Start condition plus the length and starting state latched with it.
  always_comb begin
    start_s     = tb_if.en_tb &&
                  (tb_if.i_td_full || (tb_if.i_ood && (tb_if.i_tb_len != ZERO_C)));
    start_len_s = DEPTH_C;
    start_st_s  = tb_if.i_min_st;
    if (tb_if.i_td_full) begin
      start_len_s = DEPTH_C;
    end else if (tb_if.i_tb_len > DEPTH_C) begin
      start_len_s = DEPTH_C;
    end else begin
      start_len_s = tb_if.i_tb_len;
    end
`ifdef ZERO_TERM_EN
    if (tb_if.i_td_full) begin
      start_st_s = tb_if.i_min_st;
    end else begin
      start_st_s = {ST_W{1'b0}};
    end
`else
    start_st_s = tb_if.i_min_st;
`endif
  end

  // Step k writes the bit for the oldest-first position len-1-k.
  assign wr_idx_s    = len_r - ONE_C - step_r;
  assign last_step_s = (step_r == (len_r - ONE_C));
  assign last_beat_s = (rd_idx_r == (len_r - ONE_C));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and the combinational strobes (memory read, valid).
  always_comb begin
    state_nx_s = state_r;
    tb_rd_s    = 1'b0;
    valid_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nx_s = ST_TRACE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_TRACE: begin
        if (tb_if.en_tb) begin
          tb_rd_s = 1'b1;
          if (last_step_s) begin
            state_nx_s = ST_OUTPUT;
          end else begin
            state_nx_s = ST_TRACE;
          end
        end else begin
          state_nx_s = ST_TRACE;
        end
      end
      ST_OUTPUT: begin
        if (tb_if.en_tb) begin
          valid_s = 1'b1;
          if (tb_if.i_rdy && last_beat_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_OUTPUT;
          end
        end else begin
          state_nx_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch on start, trace one stage per enabled cycle, step the
  // read index per accepted beat, flag premature memory-empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r    <= ZERO_C;
      step_r   <= ZERO_C;
      rd_idx_r <= ZERO_C;
      cur_st_r <= {ST_W{1'b0}};
      buf_r    <= {TB_DEPTH{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            len_r    <= start_len_s;
            cur_st_r <= start_st_s;
            step_r   <= ZERO_C;
            rd_idx_r <= ZERO_C;
          end
        end
        ST_TRACE: begin
          if (tb_if.en_tb) begin
            buf_r[wr_idx_s] <= cur_st_r[ST_W-1];
            cur_st_r        <= tb_if.i_bck_prv_st[cur_st_r];
            step_r          <= step_r + ONE_C;
            if (tb_if.i_td_empty) begin
              err_r <= 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (tb_if.en_tb && tb_if.i_rdy) begin
            if (last_beat_s) begin
              done_r <= 1'b1;
            end else begin
              rd_idx_r <= rd_idx_r + ONE_C;
            end
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign tb_if.o_tb_rd = tb_rd_s;
  assign tb_if.o_valid = valid_s;
  assign tb_if.o_data  = valid_s ? buf_r[rd_idx_r] : 1'b0;
  assign tb_if.o_done  = done_r;
  assign tb_if.o_busy  = (state_r != ST_IDLE);
  assign tb_if.o_err   = err_r;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench for viterbi_traceback: stimulus pushes the hand-derived
// expected bit sequence, a negedge monitor pops and compares each beat.
module tb_viterbi_traceback;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   rd_cnt;
  int   beat_cnt;
  int   done_cnt;
  bit   exp_q[$];

  viterbi_traceback_if tb_if ();

  viterbi_traceback dut (
    .clk   (clk),
    .rst   (rst),
    .tb_if (tb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  // Monitor: counts reads/beats/done pulses and checks every beat and stall.
  initial begin
    bit prev_stall;
    bit prev_data;
    bit e;
    prev_stall = 1'b0;
    prev_data  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tb_if.o_tb_rd) rd_cnt++;
        if (prev_stall) begin
          chk("stall_hold_valid", int'(tb_if.o_valid), 1);
          chk("stall_hold_data", int'(tb_if.o_data), int'(prev_data));
        end
        prev_stall = tb_if.o_valid && !tb_if.i_rdy;
        prev_data  = tb_if.o_data;
        if (tb_if.o_valid && tb_if.i_rdy) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", int'(tb_if.o_data), int'(e));
          end
        end
        if (tb_if.o_done) begin
          done_cnt++;
          chk("valid_low_at_done", int'(tb_if.o_valid), 0);
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic set_prv(input bit identity);
    for (int s = 0; s < 256; s++) begin
      tb_if.i_bck_prv_st[s] = identity ? 8'(s) : 8'h00;
    end
  endtask

  task automatic run_block(input bit full, input bit ood, input logic [5:0] tlen,
                           input logic [7:0] mst, input logic [44:0] expv,
                           input int n, input int stall_at, input int empty_at,
                           input bit exp_err);
    int  d0;
    bit  fin;
    bit  stalled;
    for (int j = 0; j < n; j++) exp_q.push_back(expv[j]);
    d0 = done_cnt;
    rd_cnt = 0;
    beat_cnt = 0;
    fin = 1'b0;
    stalled = 1'b0;
    @(posedge clk); #1;
    tb_if.en_tb = 1'b1;
    tb_if.i_td_full = full;
    tb_if.i_ood = ood;
    tb_if.i_tb_len = tlen;
    tb_if.i_min_st = mst;
    @(posedge clk); #1;
    tb_if.i_td_full = 1'b0;
    tb_if.i_ood = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && !stalled && beat_cnt == stall_at) begin
        tb_if.i_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 tb_if.i_rdy = 1'b1;
        stalled = 1'b1;
      end
      tb_if.i_td_empty = (empty_at >= 0 && rd_cnt == empty_at && tb_if.o_tb_rd);
      if (done_cnt != d0) fin = 1'b1;
    end
    tb_if.i_td_empty = 1'b0;
    chk("block_done_seen", int'(fin), 1);
    chk("tb_rd_count", rd_cnt, n);
    chk("beat_count", beat_cnt, n);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("err_flag", int'(tb_if.o_err), int'(exp_err));
    #1;
    chk("busy_after_done", int'(tb_if.o_busy), 0);
    exp_q.delete();
  endtask

  initial begin
    bit rst_hit;
    total = 0; bad = 0; rd_cnt = 0; beat_cnt = 0; done_cnt = 0;
    rst = 1'b0;
    tb_if.en_tb = 1'b0;
    tb_if.i_td_full = 1'b0;
    tb_if.i_td_empty = 1'b0;
    tb_if.i_ood = 1'b0;
    tb_if.i_tb_len = 6'd0;
    tb_if.i_min_st = 8'h00;
    tb_if.i_rdy = 1'b1;
    set_prv(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({tb_if.o_tb_rd, tb_if.o_data, tb_if.o_valid, tb_if.o_done,
              tb_if.o_busy, tb_if.o_err}), 0);
    rst = 1'b1;

    // Predecessors all 0 from 0x80: 44 zeros then a single 1.
    run_block(1'b1, 1'b0, 6'd0, 8'h80, 45'h1 << 44, 45, -1, -1, 1'b0);
    // Self-loop predecessors: MSB of the start state repeated.
    set_prv(1'b1);
    run_block(1'b1, 1'b0, 6'd0, 8'hFF, {45{1'b1}}, 45, -1, -1, 1'b0);
    run_block(1'b1, 1'b0, 6'd0, 8'h7F, 45'h0, 45, -1, -1, 1'b0);
    // Back-pressure at beat 10.
    set_prv(1'b0);
    run_block(1'b1, 1'b0, 6'd0, 8'h80, 45'h1 << 44, 45, 10, -1, 1'b0);
    // Partial block of 10 stages.
    run_block(1'b0, 1'b1, 6'd10, 8'h80, 45'h1 << 9, 10, -1, -1, 1'b0);

    // i_ood with zero length must not start anything.
    rd_cnt = 0;
    @(posedge clk); #1;
    tb_if.i_ood = 1'b1;
    tb_if.i_tb_len = 6'd0;
    @(posedge clk); #1;
    tb_if.i_ood = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ood_len0_busy", int'(tb_if.o_busy), 0);
    chk("ood_len0_reads", rd_cnt, 0);

    // Reset at trace step 20, then a normal block.
    rd_cnt = 0;
    rst_hit = 1'b0;
    @(posedge clk); #1;
    tb_if.i_td_full = 1'b1;
    tb_if.i_min_st = 8'h80;
    @(posedge clk); #1;
    tb_if.i_td_full = 1'b0;
    for (int c = 0; c < 100 && !rst_hit; c++) begin
      @(posedge clk); #1;
      if (rd_cnt == 20) rst_hit = 1'b1;
    end
    chk("reached_step20", int'(rst_hit), 1);
    rst = 1'b0;
    #1;
    chk("midreset_outputs",
        int'({tb_if.o_tb_rd, tb_if.o_data, tb_if.o_valid, tb_if.o_done,
              tb_if.o_busy, tb_if.o_err}), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    run_block(1'b1, 1'b0, 6'd0, 8'h80, 45'h1 << 44, 45, -1, -1, 1'b0);

    // Memory empty at step 30 sets a sticky error; data path unaffected.
    run_block(1'b1, 1'b0, 6'd0, 8'h80, 45'h1 << 44, 45, -1, 30, 1'b1);
    set_prv(1'b1);
    run_block(1'b1, 1'b0, 6'd0, 8'hFF, {45{1'b1}}, 45, -1, -1, 1'b1);

    // i_ood start from 0xFF with self-loop predecessors.
`ifdef ZERO_TERM_EN
    run_block(1'b0, 1'b1, 6'd10, 8'hFF, 45'h0, 10, -1, -1, 1'b1);
`else
    run_block(1'b0, 1'b1, 6'd10, 8'hFF, 45'h3FF, 10, -1, -1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Read side of the trellis diagram memory in the K=9, 256-state Viterbi decoder.
- Once the memory reports full (or the stream ends), the block starts from the best-metric state and walks predecessor pointers back through the stored stages, one stage per cycle.
- The recovered bits come out newest-first, so they are buffered.
- The buffer is then emitted oldest-first on a valid/ready bit stream toward the output interface.

Parameters:
NUM_ST, 256, number of trellis states
ST_W, 8, state index width (log2 NUM_ST)
TB_DEPTH, 45, traceback depth (5*K), stages per block
CNT_W, 6, stage counter width (must hold TB_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
en_tb  in  1  block enable; when low, FSM holds state and o_tb_rd=0
i_bck_prv_st  in  ST_W x NUM_ST  predecessor state per state for the stage currently presented by the trellis memory
i_td_full  in  1  trellis memory holds TB_DEPTH stages
i_td_empty  in  1  trellis memory read past stage 0
i_ood  in  1  out of data: partial block of i_tb_len stages is ready
i_tb_len  in  CNT_W  valid stage count when i_ood=1
i_min_st  in  ST_W  best-path-metric state from the ACS/compare unit
i_rdy  in  1  downstream ready
o_tb_rd  out  1  read strobe to trellis memory (drives its en_td); one stage per high cycle
o_data  out  1  decoded bit
o_valid  out  1  o_data valid
o_done  out  1  one-cycle pulse after last bit of the block is accepted
o_busy  out  1  FSM not in IDLE
o_err  out  1  sticky: memory reported empty before traceback finished

Behaviour:
- Reset (rst=0, async): FSM=IDLE. All outputs 0. Counters 0. Bit buffer cleared.
- FSM states:
  - IDLE -> TRACE when en_tb=1 and (i_td_full=1 or (i_ood=1 and i_tb_len!=0)). On that edge, latch len and cur_st.
    - len = TB_DEPTH if i_td_full=1 (full has priority over i_ood); else min(i_tb_len, TB_DEPTH).
    - cur_st = i_min_st.
    - i_ood with i_tb_len=0: ignored, stay IDLE.
  - TRACE: o_tb_rd=1 combinationally every cycle while en_tb=1. Each such cycle:
    - buf[len-1-k] <= cur_st[ST_W-1] (MSB = newest input bit), where k = stage step 0..len-1.
    - cur_st <= i_bck_prv_st[cur_st].
    - After len steps: o_tb_rd drops, -> OUTPUT with rd index 0.
  - OUTPUT: o_valid=1, o_data=buf[idx].
    - A beat completes when o_valid&&i_rdy; then idx++.
    - While i_rdy=0, o_data and o_valid hold.
    - After beat idx=len-1 completes: o_done=1 for one cycle, FSM -> IDLE, o_valid=0 that cycle.
- Latency: first o_valid is 1+len cycles after the start condition is sampled. Minimum block time is 1+2*len cycles.
- en_tb=0 in TRACE/OUTPUT: freeze all state, o_tb_rd=0, o_valid=0.
- i_td_empty=1 sampled in TRACE before step len-1 completes: o_err<=1 (sticky until reset). Traceback continues unchanged.
- i_td_full / i_ood while not IDLE: ignored.
- Reset mid-operation: immediate return to reset values. Partial buffer discarded, no o_done.
- State index arithmetic is unsigned ST_W bits. Predecessor lookup is a NUM_ST:1 mux.

Optional Feature:
- Macro ZERO_TERM_EN.
- Defined: on an i_ood-triggered start, cur_st is latched as 0 (zero-tail terminated frame). i_min_st is used only for i_td_full starts.
- Undefined: every start latches i_min_st.

Test Plan:
- All i_bck_prv_st entries 8'h00, i_min_st=8'h80, i_td_full pulse -> 45 o_tb_rd cycles, then 45 beats: 44 zeros then one 1; o_done pulse after beat 45; o_err=0.
- i_bck_prv_st[s]=s, i_min_st=8'hFF, full -> 45 ones. Repeat with i_min_st=8'h7F -> 45 zeros.
- Same as first case with i_rdy=0 for 3 cycles at beat 10 -> o_data/o_valid stable for those 3 cycles; total 45 beats, no duplicates.
- i_ood=1, i_tb_len=10, i_min_st=8'h80, predecessors 8'h00 -> exactly 10 o_tb_rd cycles and 10 beats (9 zeros, then 1). i_tb_len=0 -> stays IDLE.
- rst low during TRACE step 20 -> all outputs 0 next sample. New full start afterwards -> normal 45-bit block.
- Assert i_td_empty at TRACE step 30 -> o_err=1 and held through block and later blocks. With ZERO_TERM_EN and i_ood start at i_min_st=8'hFF -> first traced state 0, output last bit 0.
